uart_apb_tx: RTL
================

# uart_apb_tx

APB-attached UART transmit block that consumes the APB transactions driven by the UART bench/interface layer. It decodes APB accesses into a small register file, buffers written bytes in a TX FIFO, generates the bit-rate tick (`baud_o`) and serializes frames on `txd`. It drives `Prdata`, `Pready`, `Pslverr` and `IRQ` back to the APB side.

## Interface
- `FIFO_DEPTH`, default 16: TX FIFO entries; power of 2, at least 2.
- `DIV_W`, default 16: baud divisor width.
- `clk` input 1: single clock; all logic on the rising edge.
- `Presetn` input 1: asynchronous, active-low reset.
- `Paddr` input 32: byte address; only `[7:0]` decoded.
- `Psel` input 1: APB select.
- `Penable` input 1: APB access phase.
- `Pwrite` input 1: 1 = write, 0 = read.
- `Pwdata` input 32: write data.
- `Prdata` output 32: read data.
- `Pready` output 1: tied 1; every access completes with zero wait states.
- `Pslverr` output 1: error response for the current access.
- `IRQ` output 1: level interrupt, registered.
- `baud_o` output 1: one-cycle pulse at each bit-period boundary.
- `txd` output 1: serial output; idles high.

## Operation
- An access is `Psel & Penable`. Writes commit on the rising edge that ends the access.
- `Prdata` and `Pslverr` are combinational during an access and are 0 otherwise.
- Register map:
  - 0x00 TXDATA (write-only): pushes `Pwdata[7:0]`. Reads return 0.
  - 0x04 STATUS (read):
    - bit0 full
    - bit1 empty
    - bit2 busy (FSM not in IDLE)
    - bit3 ovf (sticky)
    - `[15:8]` FIFO count
    - Writing 1 to bit3 clears ovf. All other STATUS bits ignore writes.
  - 0x08 CTRL (read/write `[4:0]`, reset 0):
    - bit0 tx_en
    - bit1 irq_en
    - bit2 par_en
    - bit3 par_odd
    - bit4 two_stop
  - 0x0C DIV (read/write `[DIV_W-1:0]`, reset 0). Bit period is DIV+1 clocks.
  - Any other offset: `Pslverr` = 1. Writes are ignored and reads return 0.
- Push to a full FIFO:
  - Full is evaluated before any pop in the same cycle.
  - The byte is dropped, ovf is set and `Pslverr` = 1.
- Push and pop in the same cycle on a non-full FIFO: both happen and the count is unchanged.
- Baud counter:
  - Counts 0..DIV and wraps. `baud_o` = 1 in the cycle the count equals DIV.
  - Held at 0 while tx_en = 0. A DIV write takes effect at the next wrap.
- TX FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2. It advances only on `baud_o`.
  - IDLE → START: tx_en & !empty. Pop one byte into the shift register; `txd` = 0.
  - START → DATA: 8 bits, LSB first; a 3-bit bit counter.
  - DATA → PARITY if par_en, else STOP1. Parity = XOR of the data bits, inverted if par_odd.
  - PARITY → STOP1.
  - STOP1 → STOP2 if two_stop, else IDLE. Stop bits drive `txd` = 1.
  - STOP2 → IDLE.
  - Clearing tx_en mid-frame finishes the current frame. The FSM then stays in IDLE with the counter held.
- `IRQ` is registered: irq_en & (empty & !busy | ovf).

## Timing
- Reset values:
  - `txd` = 1, `IRQ` = 0, `baud_o` = 0.
  - `Prdata` = 0, `Pslverr` = 0, `Pready` = 1.
  - FIFO empty, ovf = 0, CTRL = 0, DIV = 0, FSM in IDLE.
- Reset is asynchronous. It aborts a frame in progress and `txd` goes high immediately.
- A write to TXDATA is visible in STATUS.count on a read the next cycle.
- The start bit begins at the first `baud_o` after the FIFO is non-empty with tx_en = 1.
- Each bit lasts exactly DIV+1 clocks. With DIV = 0, every cycle is a bit period.
- Frame length in bit periods: 10, plus 1 with parity, plus 1 with two_stop.
- `IRQ` lags its condition by one clock.

## Structure
- Package `uart_apb_pkg` holds:
  - Register offset constants `ADDR_TXDATA`, `ADDR_STATUS`, `ADDR_CTRL`, `ADDR_DIV`.
  - CTRL and STATUS bit index constants.
  - `tx_state_e` enum for the FSM.
- Sub-module `uart_tx_fifo`: a synchronous FIFO with push/pop/full/empty/count and a pointer wrap using an extra MSB. It is parameterized by `FIFO_DEPTH` and reset by `Presetn`.
- The top level holds APB decode, the registers, the baud counter and the FSM.

## Test plan
- Reset, then read all four registers. STATUS = 0x0000_0002 and the others read 0; `txd` = 1, `IRQ` = 0.
- Set DIV = 3 and CTRL = 0x01, then write 0x55.
  - `txd` carries 0, 1,0,1,0,1,0,1,0 (LSB first), then 1.
  - Each bit lasts 4 clocks; the frame lasts 40 clocks.
  - STATUS reads busy during the frame and empty/idle afterwards.
- Set CTRL = 0x1D (tx_en, par_en, par_odd, two_stop), then write 0x03. The frame is 12 bits, the parity bit = 1, and there are 2 stop bits.
- With tx_en = 0, write 17 bytes.
  - The 17th write gets `Pslverr` = 1 and STATUS shows ovf = 1 with count = 16.
  - With irq_en set, `IRQ` = 1.
  - Writing 0x8 to STATUS clears ovf; `IRQ` then drops one clock after the clear commits.
- Accesses to 0x10 and 0xFC return `Pslverr` = 1 and `Prdata` = 0, and no register changes.
- Deassert `Presetn` mid-frame at DATA bit 4. `txd` goes to 1 asynchronously; after release, the FIFO is empty and CTRL = 0.

Source files
------------

// File: rtl/uart_apb_pkg.sv
// Shared constants and types for the APB UART transmitter.
package uart_apb_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CTRL_W = 5;

  localparam logic [ADDR_W-1:0] ADDR_TXDATA = 8'h00;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 8'h04;
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 8'h08;
  localparam logic [ADDR_W-1:0] ADDR_DIV    = 8'h0C;

  localparam int unsigned CTRL_TX_EN    = 0;
  localparam int unsigned CTRL_IRQ_EN   = 1;
  localparam int unsigned CTRL_PAR_EN   = 2;
  localparam int unsigned CTRL_PAR_ODD  = 3;
  localparam int unsigned CTRL_TWO_STOP = 4;

  localparam int unsigned STAT_FULL    = 0;
  localparam int unsigned STAT_EMPTY   = 1;
  localparam int unsigned STAT_BUSY    = 2;
  localparam int unsigned STAT_OVF     = 3;
  localparam int unsigned STAT_CNT_LSB = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the APB TXDATA register and the transmit FSM.
module uart_tx_fifo
  import uart_apb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DATA_W-1:0]            wdata,
  output logic [DATA_W-1:0]            rdata_c,
  output logic                         full_c,
  output logic                         empty_c,
  output logic [$clog2(FIFO_DEPTH):0]  count_c
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q;
  logic [AW:0]       rd_ptr_q;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_c = (wr_ptr_q == rd_ptr_q);
  assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_c = wr_ptr_q - rd_ptr_q;
  assign rdata_c = mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full_c) begin
      mem[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push && !full_c) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop && !empty_c) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_apb_tx.sv
// APB-attached UART transmitter: register file, baud generator and frame serializer.
module uart_apb_tx
  import uart_apb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_W      = 16
) (
  input  logic        clk,
  input  logic        Presetn,
  input  logic [31:0] Paddr,
  input  logic        Psel,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        Pready,
  output logic        Pslverr,
  output logic        IRQ,
  output logic        baud_o,
  output logic        txd
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [ADDR_W-1:0] addr;
  logic              access_c, wr_c, rd_c;
  logic              sel_txdata_c, sel_status_c, sel_ctrl_c, sel_div_c, addr_ok_c;
  logic              push_req_c, pop_c;
  logic              fifo_full_c, fifo_empty_c;
  logic [CNT_W-1:0]  fifo_count_c;
  logic [DATA_W-1:0] fifo_rdata_c;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DIV_W-1:0]  div_q, div_cur_q, baud_cnt_q;
  logic              ovf_q, irq_q, txd_q, txd_d;
  logic              busy_c, run_c, baud_c;
  tx_state_e         state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] tx_byte_q, tx_byte_d;
  logic [31:0]       status_c;
  logic              unused_ok;

  assign addr         = Paddr[ADDR_W-1:0];
  assign access_c     = Psel & Penable;
  assign wr_c         = access_c & Pwrite;
  assign rd_c         = access_c & ~Pwrite;
  assign sel_txdata_c = (addr == ADDR_TXDATA);
  assign sel_status_c = (addr == ADDR_STATUS);
  assign sel_ctrl_c   = (addr == ADDR_CTRL);
  assign sel_div_c    = (addr == ADDR_DIV);
  assign addr_ok_c    = sel_txdata_c | sel_status_c | sel_ctrl_c | sel_div_c;
  assign push_req_c   = wr_c & sel_txdata_c;
  assign unused_ok    = ^{Paddr[31:ADDR_W], Pwdata};

  assign Pready = 1'b1;
  assign busy_c = (state_q != ST_IDLE);
  assign status_c = 32'({8'(fifo_count_c), 4'b0000, ovf_q, busy_c, fifo_empty_c, fifo_full_c});

  uart_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (Presetn),
    .push    (push_req_c),
    .pop     (pop_c),
    .wdata   (Pwdata[DATA_W-1:0]),
    .rdata_c (fifo_rdata_c),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c),
    .count_c (fifo_count_c)
  );

  // APB read mux and error response; both are zero outside an access.
  always_comb begin
    Prdata  = '0;
    Pslverr = 1'b0;
    if (access_c) begin
      Pslverr = ~addr_ok_c | (push_req_c & fifo_full_c);
      if (rd_c) begin
        if (sel_status_c) Prdata = status_c;
        if (sel_ctrl_c)   Prdata = 32'(ctrl_q);
        if (sel_div_c)    Prdata = 32'(div_q);
      end
    end
  end

  always_ff @(posedge clk or negedge Presetn) begin
    if (!Presetn) begin
      ctrl_q <= '0;
      div_q  <= '0;
      ovf_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      if (wr_c && sel_ctrl_c) ctrl_q <= Pwdata[CTRL_W-1:0];
      if (wr_c && sel_div_c)  div_q  <= Pwdata[DIV_W-1:0];
      if (push_req_c && fifo_full_c) begin
        ovf_q <= 1'b1;
      end else if (wr_c && sel_status_c && Pwdata[STAT_OVF]) begin
        ovf_q <= 1'b0;
      end
      irq_q <= ctrl_q[CTRL_IRQ_EN] & ((fifo_empty_c & ~busy_c) | ovf_q);
    end
  end

  assign IRQ = irq_q;

  // Baud counter keeps running while a frame drains even if tx_en was cleared.
  assign run_c  = ctrl_q[CTRL_TX_EN] | busy_c;
  assign baud_c = run_c & (baud_cnt_q == div_cur_q);
  assign baud_o = baud_c;

  always_ff @(posedge clk or negedge Presetn) begin
    if (!Presetn) begin
      baud_cnt_q <= '0;
      div_cur_q  <= '0;
    end else if (!run_c || baud_c) begin
      baud_cnt_q <= '0;
      div_cur_q  <= div_q;
    end else begin
      baud_cnt_q <= baud_cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge Presetn) begin
    if (!Presetn) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      tx_byte_q <= '0;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      tx_byte_q <= tx_byte_d;
      txd_q     <= txd_d;
    end
  end

  // Frame sequencing; every transition is gated by a bit-period tick.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    tx_byte_d = tx_byte_q;
    txd_d     = txd_q;
    pop_c     = 1'b0;
    if (baud_c) begin
      unique case (state_q)
        ST_IDLE: begin
          if (ctrl_q[CTRL_TX_EN] && !fifo_empty_c) begin
            pop_c     = 1'b1;
            tx_byte_d = fifo_rdata_c;
            txd_d     = 1'b0;
            state_d   = ST_START;
          end
        end
        ST_START: begin
          bit_cnt_d = 3'd0;
          txd_d     = tx_byte_q[0];
          state_d   = ST_DATA;
        end
        ST_DATA: begin
          if (bit_cnt_q == 3'd7) begin
            if (ctrl_q[CTRL_PAR_EN]) begin
              txd_d   = (^tx_byte_q) ^ ctrl_q[CTRL_PAR_ODD];
              state_d = ST_PARITY;
            end else begin
              txd_d   = 1'b1;
              state_d = ST_STOP1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            txd_d     = tx_byte_q[bit_cnt_d];
          end
        end
        ST_PARITY: begin
          txd_d   = 1'b1;
          state_d = ST_STOP1;
        end
        ST_STOP1: begin
          txd_d   = 1'b1;
          state_d = ctrl_q[CTRL_TWO_STOP] ? ST_STOP2 : ST_IDLE;
        end
        ST_STOP2: begin
          txd_d   = 1'b1;
          state_d = ST_IDLE;
        end
        default: begin
          txd_d   = 1'b1;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign txd = txd_q;

endmodule
